// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time, presents {pc, instr} to IF/ID.
// Latency: grant -> if_valid_o is (rvalid cycle)+1; best case one instruction every 3 cycles (REQ, WAIT, HOLD).
// Backpressure: if_ready_i low holds {pc, instr} stable in HOLD with no new request; optional misalign trap under IF_MISALIGN_TRAP_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
`ifdef IF_MISALIGN_TRAP_EN
    localparam logic [2:0] ST_FAULT = 3'd4;
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        vld_q, vld_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] redir_pc;

    // Redirect PC: raw target when trapping misalignment, otherwise low bits forced to zero.
`ifdef IF_MISALIGN_TRAP_EN
    logic tgt_mis;
    assign tgt_mis  = (branch_target_i[1:0] != 2'b00);
    assign redir_pc = branch_target_i;
`else
    assign redir_pc = branch_target_i & ~32'd3;
`endif

    // Next-state / next-PC logic for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        vld_d   = vld_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        case (state_q)
            ST_BOOT: begin
                // A response from a request abandoned by reset may still arrive; ignore it until our first grant.
                kill_d  = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (branch_taken_i) begin
                    pc_d = redir_pc;
                    if (imem_gnt_i) begin
                        // Old-address request is already in flight; drop its response.
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
`ifdef IF_MISALIGN_TRAP_EN
                        if (tgt_mis) state_d = ST_FAULT;
`endif
                    end
                end else if (imem_gnt_i) begin
                    kill_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (branch_taken_i) begin
                    pc_d = redir_pc;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
`ifdef IF_MISALIGN_TRAP_EN
                        if (tgt_mis) state_d = ST_FAULT;
`endif
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
`ifdef IF_MISALIGN_TRAP_EN
                        // A misaligned PC here means a trap was waiting for the killed response to drain.
                        if (pc_q[1:0] != 2'b00) state_d = ST_FAULT;
`endif
                    end else begin
                        vld_d   = 1'b1;
                        ipc_d   = pc_q;
                        instr_d = imem_rdata_i;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken_i) begin
                    // Redirect wins over a simultaneous accept: next PC is the target, not pc+4.
                    pc_d    = redir_pc;
                    vld_d   = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = ST_REQ;
`ifdef IF_MISALIGN_TRAP_EN
                    if (tgt_mis) state_d = ST_FAULT;
`endif
                end else if (if_ready_i) begin
                    pc_d    = pc_q + 32'd4;
                    vld_d   = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = ST_REQ;
                end
            end
`ifdef IF_MISALIGN_TRAP_EN
            ST_FAULT: begin
                if (branch_taken_i) begin
                    pc_d = redir_pc;
                    if (!tgt_mis) state_d = ST_REQ;
                end
            end
`endif
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            vld_q   <= 1'b0;
            ipc_q   <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            vld_q   <= vld_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req_o  = (state_q == ST_REQ);
    assign imem_addr_o = pc_q;
    assign if_valid_o  = vld_q;
    assign if_pc_o     = ipc_q;
    assign if_instr_o  = instr_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign misalign_o  = (state_q == ST_FAULT);
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with an imem responder model.
// Latency: responder returns rvalid rv_delay cycles after each grant.
// Backpressure: if_ready_i and imem_gnt_i are driven directly by the stimulus.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b1;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Responder / monitor state
    logic        gnt_en = 1'b1;
    int          rv_delay = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_dat = 32'h0;
    logic [31:0] req_log [$];
    logic        dead_seen = 1'b0;
    logic        seen20 = 1'b0;

    if_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef IF_MISALIGN_TRAP_EN
        .misalign_o      (misalign_o),
`endif
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_ready_i      (if_ready_i),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Edge monitor: log granted addresses, schedule responses, watch presented data.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                req_log.push_back(imem_addr_o);
                pend  = 1'b1;
                cnt   = rv_delay;
                paddr = imem_addr_o;
            end
            if (if_valid_o && if_instr_o == 32'hDEAD_BEEF) dead_seen = 1'b1;
            if (if_valid_o && if_pc_o == 32'h0000_0020) seen20 = 1'b1;
        end
    end

    // Responder: drives gnt/rvalid/rdata mid-cycle.
    always @(negedge clk) begin
        imem_rvalid_i = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = ovr_en ? ovr_dat : data_of(paddr);
                ovr_en = 1'b0;
                pend   = 1'b0;
            end
        end
        imem_gnt_i = gnt_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!if_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!if_valid_o) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] exp_log [12];
    logic        stall_ok;

    initial begin
        exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h10, 32'h80, 32'h20,
                    32'h40, 32'hFFFF_FFFC, 32'h0,
`ifdef IF_MISALIGN_TRAP_EN
                    32'h200};
`else
                    32'h100};
`endif
        // Reset state
        repeat (3) tick();
        check("rst_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst_instr", if_instr_o, 32'h0000_0013);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);

        // Release; redirect during BOOT must be ignored
        rst_n = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 32'h300;
        tick();
        branch_taken_i = 1'b0;
        check("boot_req", {31'd0, imem_req_o}, 32'd1);
        check("boot_addr", imem_addr_o, 32'h0);
        tick();
        check("wait_noreq", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("first_vld", {31'd0, if_valid_o}, 32'd1);
        check("first_pc", if_pc_o, 32'h0);
        check("first_instr", if_instr_o, data_of(32'h0));
        tick();
        wait_vld("pc4");
        check("pc4", if_pc_o, 32'h4);
        tick();
        if_ready_i = 1'b0;

        // Stall in HOLD at pc 0x8
        wait_vld("pc8");
        check("pc8", if_pc_o, 32'h8);
        stall_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(if_valid_o && if_pc_o == 32'h8 && if_instr_o == data_of(32'h8) && !imem_req_o))
                stall_ok = 1'b0;
        end
        check("stall_hold", {31'd0, stall_ok}, 32'd1);
        check("stall_nreq", req_log.size(), 32'd3);
        if_ready_i = 1'b1;
        tick();
        check("after_stall_req", {31'd0, imem_req_o}, 32'd1);
        check("after_stall_addr", imem_addr_o, 32'hC);

        // Redirect in WAIT (no rvalid yet); late response carries 0xDEADBEEF
        rv_delay = 2;
        ovr_en = 1'b1;
        ovr_dat = 32'hDEAD_BEEF;
        tick();
        branch_taken_i = 1'b1;
        branch_target_i = 32'h100;
        tick();
        branch_taken_i = 1'b0;
        rv_delay = 1;
        check("wait_kill_noreq", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("wait_redir_req", {31'd0, imem_req_o}, 32'd1);
        check("wait_redir_addr", imem_addr_o, 32'h100);
        wait_vld("pc100");
        check("pc100", if_pc_o, 32'h100);
        check("instr100", if_instr_o, data_of(32'h100));

        // Redirect in HOLD with ready high: to 0x10, then 0x10 -> 0x80
        branch_taken_i = 1'b1;
        branch_target_i = 32'h10;
        tick();
        branch_taken_i = 1'b0;
        check("hold_redir_drop", {31'd0, if_valid_o}, 32'd0);
        check("hold_redir_addr", imem_addr_o, 32'h10);
        wait_vld("pc10");
        check("pc10", if_pc_o, 32'h10);
        branch_taken_i = 1'b1;
        branch_target_i = 32'h80;
        tick();
        branch_taken_i = 1'b0;
        check("redir_beats_ready", imem_addr_o, 32'h80);
        wait_vld("pc80");

        // Redirect in REQ with grant same cycle at 0x20, target 0x40
        branch_taken_i = 1'b1;
        branch_target_i = 32'h20;
        tick();
        check("req20_addr", imem_addr_o, 32'h20);
        branch_target_i = 32'h40;
        tick();
        branch_taken_i = 1'b0;
        check("kill_wait", {31'd0, imem_req_o}, 32'd0);
        wait_vld("pc40");
        check("pc40", if_pc_o, 32'h40);
        check("instr40", if_instr_o, data_of(32'h40));

        // Redirect in REQ without grant, then wrap at 0xFFFFFFFC
        gnt_en = 1'b0;
        tick();
        check("nognt_addr", imem_addr_o, 32'h44);
        branch_taken_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_taken_i = 1'b0;
        check("nognt_redir_req", {31'd0, imem_req_o}, 32'd1);
        check("nognt_redir_addr", imem_addr_o, 32'hFFFF_FFFC);
        gnt_en = 1'b1;
        wait_vld("pcfffc");
        check("pc_fffc", if_pc_o, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", imem_addr_o, 32'h0);
        wait_vld("pc0b");

        // Misaligned redirect to 0x102
        branch_taken_i = 1'b1;
        branch_target_i = 32'h102;
        tick();
        branch_taken_i = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        check("mis_set", {31'd0, misalign_o}, 32'd1);
        check("mis_valid", {31'd0, if_valid_o}, 32'd0);
        stall_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (imem_req_o || !misalign_o) stall_ok = 1'b0;
            tick();
        end
        check("mis_noreq", {31'd0, stall_ok}, 32'd1);
        branch_taken_i = 1'b1;
        branch_target_i = 32'h200;
        tick();
        branch_taken_i = 1'b0;
        check("mis_clr", {31'd0, misalign_o}, 32'd0);
        check("mis_req_addr", imem_addr_o, 32'h200);
`else
        check("align_req", {31'd0, imem_req_o}, 32'd1);
        check("align_addr", imem_addr_o, 32'h100);
`endif
        tick();

        check("deadbeef_never", {31'd0, dead_seen}, 32'd0);
        check("pc20_never", {31'd0, seen20}, 32'd0);
        check("reqlog_size", req_log.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < req_log.size()) check($sformatf("reqlog%0d", i), req_log[i], exp_log[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
